pc_unit: RTL and testbench

Parametrised, registered program-counter unit for the multicycle RISC core, succeeding the 8-bit combinational next-PC logic. It holds the PC register and computes the next PC for sequential, branch, absolute jump and register-indirect jump-and-link flows. It adds a hardware return-address stack (RAS) for call/return and sticky overflow/underflow error flags. The PC advances only on the cycles the multicycle controller asserts `pc_en`.

---
 rtl/pc_unit.sv | 194 +++++++++++++++++++
 tb/tb_pc_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: registered program counter with next-PC selection, a circular
// return-address stack (RAS) for call/return, and sticky error flags.
//
// Interface timing: there is no valid/ready handshake on this block. pc_en is
// a plain commit qualifier from the multicycle controller: when it is high on
// a rising edge, PC, RAS and flag events take effect; when low, all state
// holds (except clr_err, which acts on every edge). next_pc is purely
// combinational from the current inputs and registered state.
module pc_unit #(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      OFF_W     = 4,
   parameter int unsigned      RAS_DEPTH = 4,
   parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pc_en,
   input  logic [2:0]       mode,
   input  logic             branch,
   input  logic [WIDTH-1:0] ins,
   input  logic [WIDTH-1:0] rm,
   input  logic [WIDTH-1:0] rd,
   input  logic             clr_err,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] next_pc,
   output logic [WIDTH-1:0] ras_top,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_ovf,
   output logic             ras_unf
);

   // Pointer addresses RAS_DEPTH slots; count spans 0..RAS_DEPTH inclusive.
   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] PC_ONE   = WIDTH'(1);

   localparam logic [2:0] MODE_SEQ    = 3'b000;
   localparam logic [2:0] MODE_BRANCH = 3'b001;
   localparam logic [2:0] MODE_JMP    = 3'b010;
   localparam logic [2:0] MODE_JAL_RM = 3'b011;
   localparam logic [2:0] MODE_JAL_RD = 3'b100;
   localparam logic [2:0] MODE_CALL   = 3'b101;
   localparam logic [2:0] MODE_RET    = 3'b110;
   localparam logic [2:0] MODE_ILL    = 3'b111;

   // Registered state.
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;          // next slot to write
   logic [WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [WIDTH-1:0] mem_d [RAS_DEPTH];
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   // Decoded helpers.
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] off_sext;
   logic [WIDTH-1:0] rel_target;
   logic [PTR_W-1:0] top_idx;
   logic [PTR_W-1:0] ptr_inc;
   logic             is_empty;
   logic             is_full;
   logic             push_req;
   logic             pop_req;
   logic             ill_req;

   // Arithmetic helpers and RAS occupancy/index decode.
   always_comb begin
      pc_inc     = pc_q + PC_ONE;
      off_sext   = {{(WIDTH-OFF_W){ins[OFF_W-1]}}, ins[OFF_W-1:0]};
      rel_target = pc_q + off_sext;
      is_empty   = (cnt_q == '0);
      is_full    = (cnt_q == CNT_FULL);
      // Top of stack sits one slot behind the write pointer, wrapping.
      top_idx    = (ptr_q == '0) ? PTR_LAST : (ptr_q - PTR_ONE);
      ptr_inc    = (ptr_q == PTR_LAST) ? '0 : (ptr_q + PTR_ONE);
   end

   // Mode decode into stack operations; modes are mutually exclusive.
   always_comb begin
      push_req = 1'b0;
      pop_req  = 1'b0;
      ill_req  = 1'b0;
      case (mode)
         MODE_JAL_RM,
         MODE_JAL_RD,
         MODE_CALL:   push_req = 1'b1;
         MODE_RET:    pop_req  = 1'b1;
         MODE_ILL:    ill_req  = 1'b1;
         default:     ;
      endcase
   end

   // Next-PC select; each mode reads only the inputs it owns so X on unused
   // operands cannot leak into the target.
   always_comb begin
      next_pc = pc_inc;
      case (mode)
         MODE_SEQ:    next_pc = pc_inc;
         MODE_BRANCH: next_pc = branch ? rel_target : pc_inc;
         MODE_JMP:    next_pc = ins;
         MODE_JAL_RM: next_pc = rm;
         MODE_JAL_RD: next_pc = rd;
         MODE_CALL:   next_pc = rel_target;
         MODE_RET:    next_pc = is_empty ? RESET_PC : mem_q[top_idx];
         MODE_ILL:    next_pc = pc_inc;
         default:     next_pc = pc_inc;
      endcase
   end

   // Next-state for PC, RAS and sticky flags; error sets override clr_err.
   always_comb begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
      ptr_d = ptr_q;
      mem_d = mem_q;
      ovf_d = ovf_q & ~clr_err;
      unf_d = unf_q & ~clr_err;

      if (pc_en) begin
         pc_d = next_pc;

         if (push_req) begin
            // When full the write slot is the oldest entry, so writing there
            // and advancing the pointer discards it.
            mem_d[ptr_q] = pc_inc;
            ptr_d        = ptr_inc;
            if (is_full) begin
               ovf_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         if (pop_req) begin
            if (is_empty) begin
               unf_d = 1'b1;
            end else begin
               ptr_d = top_idx;
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         if (ill_req) begin
            ovf_d = 1'b1;
            unf_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset that discards the whole stack.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RESET_PC;
         cnt_q <= '0;
         ptr_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         for (int i = 0; i < int'(RAS_DEPTH); i++) begin
            mem_q[i] <= RESET_PC;
         end
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
         ptr_q <= ptr_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
         mem_q <= mem_d;
      end
   end

   // Output drive from registered state.
   always_comb begin
      pc        = pc_q;
      ras_top   = is_empty ? RESET_PC : mem_q[top_idx];
      ras_empty = is_empty;
      ras_full  = is_full;
      ras_ovf   = ovf_q;
      ras_unf   = unf_q;
   end

   // Structural invariants of the circular buffer.
   a_cnt_range : assert property (@(posedge clk) disable iff (rst)
      cnt_q <= CNT_FULL);
   a_ptr_range : assert property (@(posedge clk) disable iff (rst)
      ptr_q <= PTR_LAST);

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios followed by random traffic, all
// checked by a scoreboard fed from a queue-based reference model.
module tb_pc_unit;

   localparam int         W   = 8;
   localparam int         D   = 4;
   localparam logic [7:0] RPC = 8'h00;
   // Expected entry: {known, pc, next_pc, top, empty, full, ovf, unf}
   localparam int         EW  = 1 + 3 * W + 4;

   // ---------------- clock / reset / DUT ----------------
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         pc_en = 1'b0;
   logic [2:0]   mode = 3'b000;
   logic         branch = 1'b0;
   logic [W-1:0] ins = '0;
   logic [W-1:0] rm = '0;
   logic [W-1:0] rd = '0;
   logic         clr_err = 1'b0;
   logic [W-1:0] pc, next_pc, ras_top;
   logic         ras_empty, ras_full, ras_ovf, ras_unf;

   always #5 clk = ~clk;

   pc_unit #(.WIDTH(W), .OFF_W(4), .RAS_DEPTH(D), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .pc_en(pc_en), .mode(mode), .branch(branch),
      .ins(ins), .rm(rm), .rd(rd), .clr_err(clr_err),
      .pc(pc), .next_pc(next_pc), .ras_top(ras_top),
      .ras_empty(ras_empty), .ras_full(ras_full),
      .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   // ---------------- reference model ----------------
   // Stack kept as a plain queue: back is the most recent return address.
   logic [W-1:0] m_pc = '0;
   logic [W-1:0] m_ras[$];
   logic         m_ovf = 1'b0;
   logic         m_unf = 1'b0;
   logic         m_known = 1'b0;

   function automatic logic [W-1:0] rel(input logic [W-1:0] base, input logic [W-1:0] i);
      int off;
      off = i[3] ? int'(i[3:0]) - 16 : int'(i[3:0]);
      return W'(int'(base) + off);
   endfunction

   function automatic logic [W-1:0] m_next(input logic [2:0] md, input logic br,
                                           input logic [W-1:0] i, a, b);
      case (md)
         3'd1:    return br ? rel(m_pc, i) : W'(m_pc + 1);
         3'd2:    return i;
         3'd3:    return a;
         3'd4:    return b;
         3'd5:    return rel(m_pc, i);
         3'd6:    return (m_ras.size() == 0) ? RPC : m_ras[$];
         default: return W'(m_pc + 1);
      endcase
   endfunction

   task automatic m_apply(input logic r, en, input logic [2:0] md,
                          input logic [W-1:0] nxt, input logic clr);
      logic [W-1:0] link;
      if (r) begin
         m_pc = RPC;
         m_ras.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         m_known = 1'b1;
      end else begin
         if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
         if (en) begin
            link = W'(m_pc + 1);
            m_pc = nxt;
            if (md == 3'd3 || md == 3'd4 || md == 3'd5) begin
               m_ras.push_back(link);
               if (m_ras.size() > D) begin
                  void'(m_ras.pop_front());
                  m_ovf = 1'b1;
               end
            end else if (md == 3'd6) begin
               if (m_ras.size() == 0) m_unf = 1'b1;
               else void'(m_ras.pop_back());
            end else if (md == 3'd7) begin
               m_ovf = 1'b1;
               m_unf = 1'b1;
            end
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int            n_vec = 0;
   int            n_err = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      if (act !== exp) begin
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
         n_err++;
      end
   endtask

   // Monitor: once per cycle, away from the rising edge, compare the DUT
   // against the oldest outstanding expectation.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e[EW-1]) begin
            n_vec++;
            chk("pc",        pc,                e[EW-2 -: W]);
            chk("next_pc",   next_pc,           e[EW-2-W -: W]);
            chk("ras_top",   ras_top,           e[EW-2-2*W -: W]);
            chk("ras_empty", W'(ras_empty),     W'(e[3]));
            chk("ras_full",  W'(ras_full),      W'(e[2]));
            chk("ras_ovf",   W'(ras_ovf),       W'(e[1]));
            chk("ras_unf",   W'(ras_unf),       W'(e[0]));
         end
      end
   end

   // ---------------- driver ----------------
   // Inputs change just after the rising edge; the expectation pushed holds
   // the state committed by that edge plus next_pc for the new inputs.
   task automatic drive(input logic r, en, input logic [2:0] md, input logic br,
                        input logic [W-1:0] i, a, b, input logic clr);
      logic [W-1:0] nxt;
      logic [W-1:0] top;
      @(posedge clk);
      #1;
      rst = r; pc_en = en; mode = md; branch = br;
      ins = i; rm = a; rd = b; clr_err = clr;
      nxt = m_next(md, br, i, a, b);
      top = (m_ras.size() == 0) ? RPC : m_ras[$];
      exp_q.push_back({m_known, m_pc, nxt, top, m_ras.size() == 0,
                       m_ras.size() == D, m_ovf, m_unf});
      m_apply(r, en, md, nxt, clr);
   endtask

   task automatic do_rst();
      drive(1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic op(input logic [2:0] md, input logic [W-1:0] i, a, b, input logic br);
      drive(1'b0, 1'b1, md, br, i, a, b, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int budget;
      do_rst();
      // Sequential count and wrap at 0xFF.
      repeat (3) op(3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
      op(3'd2, 8'hFF, 8'h00, 8'h00, 1'b0);
      op(3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
      op(3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
      // Branch forward, backward, not taken.
      op(3'd2, 8'h10, 8'h00, 8'h00, 1'b0);
      op(3'd1, 8'h03, 8'h00, 8'h00, 1'b1);
      op(3'd1, 8'h0E, 8'h00, 8'h00, 1'b1);
      op(3'd1, 8'h0E, 8'h00, 8'h00, 1'b0);
      // Call via Rm, call via Rd, two returns.
      op(3'd2, 8'h20, 8'h00, 8'h00, 1'b0);
      op(3'd3, 8'h00, 8'h55, 8'h00, 1'b0);
      op(3'd4, 8'h00, 8'h00, 8'h22, 1'b0);
      op(3'd6, 8'h00, 8'h00, 8'h00, 1'b0);
      op(3'd6, 8'h00, 8'h00, 8'h00, 1'b0);
      op(3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
      // Overflow: five calls of +1 from 0x00, then four returns.
      do_rst();
      repeat (5) op(3'd5, 8'h01, 8'h00, 8'h00, 1'b0);
      repeat (4) op(3'd6, 8'h00, 8'h00, 8'h00, 1'b0);
      op(3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
      // Underflow, clear alone, clear racing a new underflow.
      do_rst();
      op(3'd2, 8'h40, 8'h00, 8'h00, 1'b0);
      op(3'd6, 8'h00, 8'h00, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
      drive(1'b0, 1'b1, 3'd6, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
      drive(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
      // Hold with a link mode presented, then mid-sequence reset.
      op(3'd2, 8'h30, 8'h00, 8'h00, 1'b0);
      op(3'd3, 8'h00, 8'h40, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 3'd3, 1'b0, 8'h00, 8'h77, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 3'd3, 1'b0, 8'h00, 8'h78, 8'h00, 1'b0);
      op(3'd5, 8'h02, 8'h00, 8'h00, 1'b0);
      do_rst();
      op(3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
      // Illegal mode sets both flags.
      op(3'd7, 8'h00, 8'h00, 8'h00, 1'b0);
      op(3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
               3'($urandom_range(0, 7)), 1'($urandom),
               8'($urandom), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 9) == 0));
      end
      drive(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      // Drain the scoreboard within a bounded number of cycles.
      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      if (exp_q.size() > 0) begin
         $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
         n_err++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
